// File: rtl/rdi_prng_if.sv
// Seed and random-data handshake bundle between the randomness source and its
// environment. The slave modport is the PRNG; the master side supplies seed
// words and consumes random words.
interface rdi_prng_if #(
    parameter int RW = 64
);
    logic [31:0]   seed_data;
    logic          seed_valid;
    logic          seed_ready;
    logic [RW-1:0] rdi_data;
    logic          rdi_valid;
    logic          rdi_ready;

    modport master (
        output seed_data, seed_valid, rdi_ready,
        input  seed_ready, rdi_data, rdi_valid
    );

    modport slave (
        input  seed_data, seed_valid, rdi_ready,
        output seed_ready, rdi_data, rdi_valid
    );
endinterface

// File: rtl/rdi_prng.sv
// Fresh-randomness source for the masked LWC core: seeded once with 128 bits,
// runs xorshift128 one 32-bit step per cycle and packs RW/32 steps into each
// RW-bit word offered on the rdi handshake. Not a certified TRNG.
module rdi_prng #(
    parameter int RW = 64
) (
    input  logic         clk,
    input  logic         rst,
    rdi_prng_if.slave    bus
);

    localparam int NW = RW / 32;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_x;
    logic [31:0]   r_y;
    logic [31:0]   r_z;
    logic [31:0]   r_w;
    logic [RW-1:0] r_buf;
    logic [KW-1:0] r_k;
    logic [1:0]    r_s;

    logic [31:0]   w_step;
    logic [RW-1:0] w_buf_shift;
    logic          w_seed_fire;
    logic          w_seed_zero;
    logic          w_fill_done;
    logic          w_seed_ready;
    logic          w_rdi_valid;

    // One xorshift128 step: new w from the oldest (x) and newest (w) words.
    function automatic logic [31:0] f_xorshift(input logic [31:0] a_x,
                                               input logic [31:0] a_w);
        logic [31:0] t;
        t = a_x ^ (a_x << 11);
        return a_w ^ (a_w >> 19) ^ t ^ (t >> 8);
    endfunction

    assign w_step      = f_xorshift(r_x, r_w);
    assign w_seed_fire = (r_state == ST_SEED) && bus.seed_valid;
    // Only consulted on the 4th seed word, when x/y/z already hold words 1..3.
    assign w_seed_zero = ({r_x, r_y, r_z, bus.seed_data} == 128'd0);
    assign w_fill_done = (r_k == K_LAST);

    // Shift the new step into the LSBs so the oldest word ends in the MSBs;
    // written this way so RW = 32 needs no special-case slice.
    always_comb begin
        w_buf_shift       = r_buf << 32;
        w_buf_shift[31:0] = w_step;
    end

    // Next-state and handshake outputs; both readies/valids depend on state only.
    always_comb begin
        w_state_next = r_state;
        w_seed_ready = 1'b0;
        w_rdi_valid  = 1'b0;
        case (r_state)
            ST_SEED: begin
                w_seed_ready = 1'b1;
                if (bus.seed_valid && (r_s == 2'd3)) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_fill_done) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                w_rdi_valid = 1'b1;
                if (bus.rdi_ready) begin
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_SEED;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SEED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Seed loading, PRNG stepping and output packing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_w   <= '0;
            r_buf <= '0;
            r_k   <= '0;
            r_s   <= '0;
        end else begin
            case (r_state)
                ST_SEED: begin
                    if (w_seed_fire) begin
                        case (r_s)
                            2'd0: r_x <= bus.seed_data;
                            2'd1: r_y <= bus.seed_data;
                            2'd2: r_z <= bus.seed_data;
                            default: r_w <= w_seed_zero ? 32'h1 : bus.seed_data;
                        endcase
                        r_s <= r_s + 2'd1;
                        r_k <= '0;
                    end
                end
                ST_FILL: begin
                    r_x   <= r_y;
                    r_y   <= r_z;
                    r_z   <= r_w;
                    r_w   <= w_step;
                    r_buf <= w_buf_shift;
                    r_k   <= w_fill_done ? '0 : r_k + KW'(1);
                end
                ST_FULL: begin
                    if (bus.rdi_ready) begin
                        r_k <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.seed_ready = w_seed_ready;
    assign bus.rdi_valid  = w_rdi_valid;
    assign bus.rdi_data   = r_buf;

endmodule

// File: tb/tb_rdi_prng.sv
// Bench for rdi_prng: randomized seeding/backpressure, scoreboard queue fed by
// a sequence-level xorshift128 model, monitor comparing on each handshake.
module tb_rdi_prng;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rdi_prng_if #(.RW(64))  ifm ();
    rdi_prng_if #(.RW(32))  if32 ();
    rdi_prng_if #(.RW(128)) if128 ();

    assign if32.seed_data   = ifm.seed_data;
    assign if32.seed_valid  = ifm.seed_valid;
    assign if32.rdi_ready   = 1'b0;
    assign if128.seed_data  = ifm.seed_data;
    assign if128.seed_valid = ifm.seed_valid;
    assign if128.rdi_ready  = 1'b0;

    rdi_prng #(.RW(64))  dut     (.clk(clk), .rst(rst), .bus(ifm.slave));
    rdi_prng #(.RW(32))  dut32   (.clk(clk), .rst(rst), .bus(if32.slave));
    rdi_prng #(.RW(128)) dut128  (.clk(clk), .rst(rst), .bus(if128.slave));

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    bit          chk_spacing = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] mq[$];
    logic [31:0] seed_t1 [4];
    logic [31:0] seed_zero [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: the stream s[n+4] = f(s[n], s[n+3]) kept as a sliding window.
    task automatic model_seed(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        mq = '{a, b, c, d};
        if ((a | b | c | d) == 32'd0) mq = '{32'd0, 32'd0, 32'd0, 32'd1};
    endtask

    task automatic model_step(output logic [31:0] o);
        logic [31:0] t;
        t = mq[0] ^ (mq[0] << 11);
        o = mq[3] ^ (mq[3] >> 19) ^ t ^ (t >> 8);
        void'(mq.pop_front());
        mq.push_back(o);
    endtask

    task automatic push_words(input int n);
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < n; i++) begin
            model_step(a);
            model_step(b);
            exp_q.push_back({a, b});
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ifm.seed_valid = 1'b0;
        ifm.rdi_ready  = 1'b0;
        chk_spacing    = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_seed_ready", ifm.seed_ready, 1);
        check("rst_rdi_valid", ifm.rdi_valid, 0);
        check("rst_rdi_data", ifm.rdi_data, 0);
        check("rst_valid32", if32.rdi_valid, 0);
        check("rst_valid128", if128.rdi_valid, 0);
        tick();
    endtask

    task automatic seed_words(input logic [31:0] w [4], input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            ifm.seed_valid = 1'b1;
            ifm.seed_data  = w[i];
            @(negedge clk);
            check("seed_ready", ifm.seed_ready, 1);
            tick();
            ifm.seed_valid = 1'b0;
            ifm.seed_data  = $urandom;
        end
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            if (rand_ready) ifm.rdi_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        ifm.rdi_ready = 1'b0;
        check("drain_remaining", exp_q.size(), 0);
    endtask

    // Monitor: handshake-driven scoreboard plus hold/stability rules.
    initial begin
        logic [63:0] prev_data;
        logic [63:0] e;
        bit          prev_valid;
        bit          prev_ready;
        bit          have_last;
        int unsigned last_hs;
        prev_valid = 0; prev_ready = 0; prev_data = '0; have_last = 0; last_hs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
                have_last  = 0;
            end else begin
                if (!chk_spacing) have_last = 0;
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", ifm.rdi_valid, 1);
                    check("hold_data", ifm.rdi_data, prev_data);
                end
                if (ifm.rdi_valid && ifm.rdi_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h expected none", ifm.rdi_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", ifm.rdi_data, e);
                        check("nonzero_hi", (ifm.rdi_data[63:32] != 32'd0), 1);
                        check("nonzero_lo", (ifm.rdi_data[31:0] != 32'd0), 1);
                    end
                    if (chk_spacing && have_last) check("spacing", cyc - last_hs, 3);
                    last_hs   = cyc;
                    have_last = 1;
                end
                prev_valid = ifm.rdi_valid;
                prev_ready = ifm.rdi_ready;
                prev_data  = ifm.rdi_data;
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s [4];
        seed_t1   = '{32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};
        seed_zero = '{32'd0, 32'd0, 32'd0, 32'd0};
        ifm.seed_valid = 1'b0;
        ifm.seed_data  = '0;
        ifm.rdi_ready  = 1'b0;

        // Test 1 + 6: latency, first word, RW=32/128 variants.
        do_reset();
        seed_words(seed_t1, 4, 1'b0);
        model_seed(seed_t1[0], seed_t1[1], seed_t1[2], seed_t1[3]);
        for (int i = 0; i < 4; i++) model_step(s[i]);
        exp_q.push_back({s[0], s[1]});
        exp_q.push_back({s[2], s[3]});
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("lat64_c%0d", c), ifm.rdi_valid, (c >= 2));
            check($sformatf("lat32_c%0d", c), if32.rdi_valid, (c >= 1));
            check($sformatf("lat128_c%0d", c), if128.rdi_valid, (c >= 4));
            tick();
        end
        check("t1_hi_word", ifm.rdi_data[63:32], 32'hDCA345EA);
        check("t1_word64", ifm.rdi_data, {s[0], s[1]});
        check("t6_word32", if32.rdi_data, 32'hDCA345EA);
        check("t6_word128", if128.rdi_data, {s[0], s[1], s[2], s[3]});

        // Test 3: backpressure with seed port noise.
        for (int i = 0; i < 50; i++) begin
            ifm.seed_valid = 1'($urandom_range(0, 1));
            ifm.seed_data  = $urandom;
            @(negedge clk);
            check("t3_seed_ready", ifm.seed_ready, 0);
            check("t3_valid", ifm.rdi_valid, 1);
            tick();
        end
        ifm.seed_valid = 1'b0;

        // Test 2: ready tied high, 1000 words at 3-cycle spacing.
        push_words(998);
        chk_spacing   = 1'b1;
        ifm.rdi_ready = 1'b1;
        drain(3200, 1'b0);
        chk_spacing = 1'b0;

        // Test 4: all-zero seed is forced to (0,0,0,1).
        do_reset();
        seed_words(seed_zero, 4, 1'b1);
        check("t4_x", dut.r_x, 0);
        check("t4_y", dut.r_y, 0);
        check("t4_z", dut.r_z, 0);
        check("t4_w", dut.r_w, 1);
        model_seed(32'd0, 32'd0, 32'd0, 32'd0);
        push_words(5000);
        ifm.rdi_ready = 1'b1;
        drain(15200, 1'b0);

        // Test 5: reset mid-seed and mid-fill, then reseed.
        do_reset();
        seed_words(seed_t1, 2, 1'b0);
        do_reset();
        seed_words(seed_t1, 4, 1'b0);
        do_reset();
        seed_words(seed_t1, 4, 1'b1);
        model_seed(seed_t1[0], seed_t1[1], seed_t1[2], seed_t1[3]);
        push_words(20);
        drain(400, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
